// File: rtl/branch_pc_ctrl.sv
// Fetch PC controller: sequential stepping, taken-branch redirects with
// flush pulses, stall-buffered redirects and a halt freeze.
module branch_pc_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branchValid,
    input  logic        jmpTrue,
    input  logic [15:0] result,
    input  logic        stall,
    input  logic        halt,
    output logic [15:0] pc,
    output logic [15:0] pcPlus2,
    output logic        flushIF,
    output logic        flushID,
    output logic        halted,
    output logic [7:0]  takenCount
);

    typedef enum logic [1:0] {
        RUN,
        PEND,
        HALTED
    } state_t;

    localparam logic [15:0] STEP = 16'(PC_STEP);

    state_t      state;
    state_t      stateNext;
    logic [15:0] pendTarget;
    logic [15:0] pendNext;
    logic [15:0] pcNext;
    logic        flushQ;
    logic        flushNext;
    logic [7:0]  countNext;
    logic        redirect;
    logic [15:0] target;
    logic [7:0]  countInc;

    // Instructions are halfword aligned, so the target LSB is discarded.
    assign redirect = branchValid & jmpTrue;
    assign target   = result & 16'hFFFE;
    assign pcPlus2  = pc + STEP;
    assign countInc = (takenCount == 8'hFF) ? takenCount : takenCount + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            pendTarget <= 16'h0000;
            flushQ     <= 1'b0;
            takenCount <= 8'h00;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            pendTarget <= pendNext;
            flushQ     <= flushNext;
            takenCount <= countNext;
        end
    end

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        pendNext  = pendTarget;
        flushNext = 1'b0;
        countNext = takenCount;
        unique case (state)
            RUN: begin
                if (redirect) begin
                    countNext = countInc;
                    if (stall) begin
                        pendNext  = target;
                        stateNext = PEND;
                    end else begin
                        pcNext    = target;
                        flushNext = 1'b1;
                    end
                end else if (!stall) begin
                    if (halt) begin
                        stateNext = HALTED;
                    end else begin
                        pcNext = pcPlus2;
                    end
                end
            end
            // The pipeline is frozen, so later branches are not yet real.
            PEND: begin
                if (!stall) begin
                    pcNext    = pendTarget;
                    flushNext = 1'b1;
                    stateNext = halt ? HALTED : RUN;
                end
            end
            HALTED: begin
                if (!halt) begin
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    assign flushIF = flushQ;
    assign flushID = flushQ;
    assign halted  = (state == HALTED);

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Scoreboard bench for branch_pc_ctrl: directed scenarios then random
// stimulus, checked against a rule-level model of the controller.
module tb_branch_pc_ctrl;

    localparam logic [15:0] RP   = 16'h0000;
    localparam int          STEP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        branchValid;
    logic        jmpTrue;
    logic [15:0] result;
    logic        stall;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pcPlus2;
    logic        flushIF;
    logic        flushID;
    logic        halted;
    logic [7:0]  takenCount;

    always #5 clk = ~clk;

    branch_pc_ctrl #(
        .RESET_PC(RP),
        .PC_STEP (STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .branchValid(branchValid),
        .jmpTrue    (jmpTrue),
        .result     (result),
        .stall      (stall),
        .halt       (halt),
        .pc         (pc),
        .pcPlus2    (pcPlus2),
        .flushIF    (flushIF),
        .flushID    (flushID),
        .halted     (halted),
        .takenCount (takenCount)
    );

    typedef struct {
        int pc;
        bit flush;
        bit halted;
        int count;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state, kept as plain flags and integers.
    int mPc      = 0;
    int mCount   = 0;
    int mPendTgt = 0;
    bit mPending = 0;
    bit mHalted  = 0;
    bit mFlush   = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit b, input bit j,
                             input int res, input bit s, input bit h);
        bit req;
        int tgt;
        req    = b && j;
        tgt    = res - (res % 2);
        mFlush = 0;
        if (r) begin
            mPc      = int'(RP);
            mCount   = 0;
            mPendTgt = 0;
            mPending = 0;
            mHalted  = 0;
        end else if (mHalted) begin
            if (!h) mHalted = 0;
        end else if (mPending) begin
            if (!s) begin
                mPc      = mPendTgt;
                mFlush   = 1;
                mPending = 0;
                mHalted  = h;
            end
        end else if (req) begin
            if (s) begin
                mPending = 1;
                mPendTgt = tgt;
            end else begin
                mPc    = tgt;
                mFlush = 1;
            end
            if (mCount < 255) mCount = mCount + 1;
        end else if (!s) begin
            if (h) mHalted = 1;
            else   mPc = (mPc + STEP) % 65536;
        end
    endtask

    task automatic drive(input bit r, input bit b, input bit j,
                         input logic [15:0] res, input bit s, input bit h);
        exp_t e;
        rst         = r;
        branchValid = b;
        jmpTrue     = j;
        result      = res;
        stall       = s;
        halt        = h;
        modelStep(r, b, j, int'(res), s, h);
        e.pc     = mPc;
        e.flush  = mFlush;
        e.halted = mHalted;
        e.count  = mCount;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 16'h0000, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", int'(pc), e.pc);
                chk("pcPlus2", int'(pcPlus2), (e.pc + STEP) % 65536);
                chk("flushIF", int'(flushIF), int'(e.flush));
                chk("flushID", int'(flushID), int'(e.flush));
                chk("halted", int'(halted), int'(e.halted));
                chk("takenCount", int'(takenCount), e.count);
            end
        end
    end

    initial begin : stim
        drive(1, 0, 0, 16'h0000, 0, 0);
        drive(1, 0, 0, 16'h0000, 0, 0);
        idle(4);
        drive(0, 1, 1, 16'h0041, 0, 0);
        idle(1);
        drive(0, 1, 0, 16'h0100, 0, 0);
        idle(1);
        drive(0, 0, 0, 16'h0000, 1, 0);
        drive(0, 1, 1, 16'h0200, 1, 0);
        drive(0, 1, 1, 16'h0300, 1, 0);
        drive(0, 0, 0, 16'h0000, 1, 0);
        idle(3);
        drive(0, 1, 1, 16'hFFFD, 0, 0);
        drive(0, 1, 1, 16'hFFFC, 0, 1);
        drive(0, 0, 0, 16'h0000, 0, 1);
        drive(0, 0, 0, 16'h0000, 0, 1);
        drive(0, 0, 0, 16'h0000, 0, 1);
        idle(4);
        drive(0, 1, 1, 16'h0500, 1, 0);
        drive(0, 0, 0, 16'h0000, 1, 0);
        drive(1, 0, 0, 16'h0000, 0, 0);
        idle(5);
        drive(0, 1, 1, 16'h0700, 1, 0);
        drive(0, 0, 0, 16'h0000, 0, 1);
        drive(0, 0, 0, 16'h0000, 0, 1);
        idle(3);
        for (int i = 0; i < 260; i++) begin
            drive(0, 1, 1, 16'($urandom), 0, 0);
        end
        idle(2);
        for (int i = 0; i < 2500; i++) begin
            drive(($urandom_range(0, 299) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  16'($urandom),
                  ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 2));
        end
        @(posedge clk);
        #5;
        chk("scoreboardDrain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
